// File: rtl/kuuga_bram_port_adapter_if.sv
// Core-side memory port: req/gnt request channel plus the in-order rvalid response channel.
interface kuuga_bram_port_adapter_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;
    logic                  err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/kuuga_bram_port_adapter.sv
// Bridges a req/gnt/rvalid core port onto a word-wide single-port BRAM, doing RMW for partial writes.
// Define KUUGA_BRAM_MISALIGN_EN to answer misaligned requests with err instead of ignoring addr[1:0].
module kuuga_bram_port_adapter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    kuuga_bram_port_adapter_if.slave    core,
    output logic                        bram_en,
    output logic [3:0]                  bram_we,
    output logic [ADDR_WIDTH-1:0]       bram_addr,
    output logic [31:0]                 bram_wrdata,
    input  logic [31:0]                 bram_rddata,
    output logic                        bram_rst
);

`ifdef KUUGA_BRAM_MISALIGN_EN
    localparam bit MisalignEn = 1'b1;
`else
    localparam bit MisalignEn = 1'b0;
`endif

    localparam int CntW = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RMW_WAIT, RMW_WRITE} state_t;

    state_t                  state;
    logic [CntW-1:0]         wait_cnt;
    logic [ADDR_WIDTH-1:0]   rmw_addr;
    logic [3:0]              rmw_be;
    logic [31:0]             rmw_wdata;
    logic                    rmw_resp;
    logic [READ_LATENCY-1:0] pipe_v;
    logic [READ_LATENCY-1:0] pipe_rd;
    logic [READ_LATENCY-1:0] pipe_err;

    logic                  fire;
    logic                  misalign;
    logic                  partial;
    logic                  start_rmw;
    logic                  push_v;
    logic                  push_rd;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign word_addr = {2'b00, core.addr[ADDR_WIDTH-1:2]};
    assign misalign  = MisalignEn && (core.addr[1:0] != 2'b00);
    assign partial   = (core.be != 4'hF) && (core.be != 4'h0);
    assign core.gnt  = (state == IDLE) && !bram_rst;
    assign fire      = core.req && core.gnt;
    assign start_rmw = fire && core.we && partial && !misalign;
    assign push_v    = fire && !start_rmw;
    assign push_rd   = fire && !core.we && !misalign;

    // RMW responses bypass the shift register: they retire one cycle after the merged write.
    assign core.rvalid = pipe_v[READ_LATENCY-1] || rmw_resp;
    assign core.rdata  = (pipe_v[READ_LATENCY-1] && pipe_rd[READ_LATENCY-1]) ? bram_rddata : 32'h0;
    assign core.err    = pipe_v[READ_LATENCY-1] && pipe_err[READ_LATENCY-1];

    always_comb begin
        bram_en     = 1'b0;
        bram_we     = 4'h0;
        bram_addr   = word_addr;
        bram_wrdata = core.wdata;
        if (state == RMW_WRITE) begin
            bram_en   = 1'b1;
            bram_we   = 4'hF;
            bram_addr = rmw_addr;
            for (int k = 0; k < 4; k++) begin
                bram_wrdata[8*k +: 8] = rmw_be[k] ? rmw_wdata[8*k +: 8] : bram_rddata[8*k +: 8];
            end
        end else if (fire && !misalign) begin
            if (!core.we) begin
                bram_en = 1'b1;
            end else if (core.be == 4'hF) begin
                bram_en = 1'b1;
                bram_we = 4'hF;
            end else if (core.be != 4'h0) begin
                bram_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_rst <= 1'b1;
        end else begin
            bram_rst <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rmw_addr  <= '0;
            rmw_be    <= 4'h0;
            rmw_wdata <= 32'h0;
            rmw_resp  <= 1'b0;
        end else begin
            rmw_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rmw) begin
                        rmw_addr  <= word_addr;
                        rmw_be    <= core.be;
                        rmw_wdata <= core.wdata;
                        wait_cnt  <= CntW'(1);
                        state     <= (READ_LATENCY == 1) ? RMW_WRITE : RMW_WAIT;
                    end
                end
                RMW_WAIT: begin
                    if (wait_cnt == CntW'(READ_LATENCY - 1)) begin
                        state <= RMW_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RMW_WRITE: begin
                    rmw_resp <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response tracker aligned with the BRAM read latency so data and valid meet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v   <= '0;
            pipe_rd  <= '0;
            pipe_err <= '0;
        end else begin
            pipe_v[0]   <= push_v;
            pipe_rd[0]  <= push_rd;
            pipe_err[0] <= fire && misalign;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_rd[i]  <= pipe_rd[i-1];
                pipe_err[i] <= pipe_err[i-1];
            end
        end
    end

endmodule

// File: tb/tb_kuuga_bram_port_adapter.sv
// Directed bench for kuuga_bram_port_adapter with a read-first BRAM model and a response scoreboard.
module tb_kuuga_bram_port_adapter;

`ifdef KUUGA_BRAM_MISALIGN_EN
    localparam bit MisEn = 1'b1;
`else
    localparam bit MisEn = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    bit          clk = 1'b0;
    logic        rst_n;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [15:0] bram_addr;
    logic [31:0] bram_wrdata;
    logic [31:0] bram_rddata;
    logic        bram_rst;

    int   tests = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rv_seen = 0;
    int   rv_before;
    int   budget;
    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] ref_mem [0:255];
    logic [31:0] bmem [0:255];
    logic [31:0] s1;
    logic [31:0] s2;
    bit          mem_ready = 1'b0;

    kuuga_bram_port_adapter_if #(.ADDR_WIDTH(16)) bus ();

    kuuga_bram_port_adapter #(
        .ADDR_WIDTH   (16),
        .READ_LATENCY (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core        (bus),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_wrdata (bram_wrdata),
        .bram_rddata (bram_rddata),
        .bram_rst    (bram_rst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first single-port memory with two cycles of read latency.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) bmem[i] = 32'hA5000000 | i;
            bmem[4] = 32'h11223344;
            mem_ready = 1'b1;
        end
        if (bram_en) begin
            s1 <= bmem[bram_addr[7:0]];
            if (bram_we == 4'hF) bmem[bram_addr[7:0]] = bram_wrdata;
        end
        s2 <= s1;
    end
    assign bram_rddata = s2;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        #3;
        if (bus.rvalid === 1'b1) begin
            rv_seen++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_rvalid", {31'b0, bus.rvalid}, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("rdata", bus.rdata, mon_e.data);
                checkOutput("err", {31'b0, bus.err}, {31'b0, mon_e.err});
                checkOutput("latency", cyc, mon_e.due);
            end
        end
    end

    // Drives one request, waits for its grant, checks the issued BRAM cycle and queues the response.
    task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [3:0] b, input logic [31:0] d);
        int          wait_cycles;
        exp_t        e;
        logic [13:0] word;
        logic        mis;
        logic        exp_en;
        logic [3:0]  exp_we;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.be    = b;
        bus.wdata = d;
        #1;
        wait_cycles = 0;
        while (bus.gnt !== 1'b1 && wait_cycles < 20) begin
            @(negedge clk);
            #1;
            wait_cycles++;
        end
        checkOutput("gnt_wait", {31'b0, bus.gnt}, 32'h1);
        if (bus.gnt === 1'b1) begin
            word   = a[15:2];
            mis    = MisEn && (a[1:0] != 2'b00);
            e.data = 32'h0;
            e.err  = 1'b0;
            e.due  = cyc + 2;
            exp_en = 1'b0;
            exp_we = 4'h0;
            if (mis) begin
                e.err = 1'b1;
            end else if (!w) begin
                e.data = ref_mem[word[7:0]];
                exp_en = 1'b1;
            end else if (b == 4'hF) begin
                ref_mem[word[7:0]] = d;
                exp_en = 1'b1;
                exp_we = 4'hF;
            end else if (b != 4'h0) begin
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) ref_mem[word[7:0]][8*k +: 8] = d[8*k +: 8];
                end
                exp_en = 1'b1;
                e.due  = cyc + 3;
            end
            checkOutput("bram_en", {31'b0, bram_en}, {31'b0, exp_en});
            checkOutput("bram_we", {28'b0, bram_we}, {28'b0, exp_we});
            if (exp_en) checkOutput("bram_addr", {16'b0, bram_addr}, {18'b0, word});
            if (exp_we == 4'hF) checkOutput("bram_wrdata", bram_wrdata, d);
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA5000000 | i;
        ref_mem[4] = 32'h11223344;
        rst_n     = 1'b0;
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 16'h0;
        bus.be    = 4'h0;
        bus.wdata = 32'h0;

        // Reset held with a pending request: nothing may be granted or issued.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            checkOutput("rst_gnt", {31'b0, bus.gnt}, 32'h0);
            checkOutput("rst_bram_en", {31'b0, bram_en}, 32'h0);
            checkOutput("rst_bram_rst", {31'b0, bram_rst}, 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("release_gnt", {31'b0, bus.gnt}, 32'h0);
        checkOutput("release_bram_rst", {31'b0, bram_rst}, 32'h1);
        @(negedge clk);
        #2;
        checkOutput("bram_rst_fall", {31'b0, bram_rst}, 32'h0);
        checkOutput("first_gnt", {31'b0, bus.gnt}, 32'h1);
        checkOutput("first_en", {31'b0, bram_en}, 32'h1);
        sb.push_back('{data: ref_mem[0], err: 1'b0, due: cyc + 2});
        @(posedge clk);

        // Back-to-back reads.
        applyStimulus(1'b0, 16'h0000, 4'h0, 32'h0);
        applyStimulus(1'b0, 16'h0004, 4'h0, 32'h0);
        applyStimulus(1'b0, 16'h0008, 4'h0, 32'h0);
        @(negedge clk);
        bus.req = 1'b0;
        repeat (3) @(negedge clk);

        // Partial write to word 0x10 with detailed RMW timing.
        applyStimulus(1'b1, 16'h0010, 4'b0010, 32'h0000AA00);
        @(negedge clk);
        bus.req = 1'b0;
        #2;
        checkOutput("rmw_gnt_n1", {31'b0, bus.gnt}, 32'h0);
        checkOutput("rmw_en_n1", {31'b0, bram_en}, 32'h0);
        @(negedge clk);
        #2;
        checkOutput("rmw_gnt_n2", {31'b0, bus.gnt}, 32'h0);
        checkOutput("rmw_rvalid_n2", {31'b0, bus.rvalid}, 32'h0);
        checkOutput("rmw_en_n2", {31'b0, bram_en}, 32'h1);
        checkOutput("rmw_we_n2", {28'b0, bram_we}, 32'hF);
        checkOutput("rmw_addr_n2", {16'b0, bram_addr}, 32'h4);
        checkOutput("rmw_wrdata_n2", bram_wrdata, 32'h1122AA44);
        @(negedge clk);
        #2;
        checkOutput("rmw_rvalid_n3", {31'b0, bus.rvalid}, 32'h1);
        checkOutput("rmw_gnt_n3", {31'b0, bus.gnt}, 32'h1);
        applyStimulus(1'b0, 16'h0010, 4'h0, 32'h0);

        // Full write then read of the same word on the next cycle.
        applyStimulus(1'b1, 16'h0020, 4'hF, 32'hDEADBEEF);
        applyStimulus(1'b0, 16'h0020, 4'h0, 32'h0);

        // A read in flight ahead of an RMW, then a request stalled behind it.
        applyStimulus(1'b0, 16'h0000, 4'h0, 32'h0);
        applyStimulus(1'b1, 16'h0008, 4'b1001, 32'hCC0000DD);
        applyStimulus(1'b0, 16'h0008, 4'h0, 32'h0);

        // Empty byte mask: no memory change.
        applyStimulus(1'b1, 16'h0024, 4'h0, 32'h12345678);
        applyStimulus(1'b0, 16'h0024, 4'h0, 32'h0);
        @(negedge clk);
        bus.req = 1'b0;
        repeat (4) @(negedge clk);

        // Reset with two reads in flight: their responses must vanish.
        applyStimulus(1'b0, 16'h0000, 4'h0, 32'h0);
        applyStimulus(1'b0, 16'h0004, 4'h0, 32'h0);
        #1;
        rst_n   = 1'b0;
        bus.req = 1'b0;
        sb.delete();
        rv_before = rv_seen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("post_reset_idle_gnt", {31'b0, bus.gnt}, 32'h1);
        repeat (4) @(negedge clk);
        checkOutput("no_rvalid_after_reset", rv_seen, rv_before);
        applyStimulus(1'b0, 16'h0010, 4'h0, 32'h0);

        // Misaligned read.
        applyStimulus(1'b0, 16'h0006, 4'h0, 32'h0);
        @(negedge clk);
        bus.req = 1'b0;

        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        repeat (2) @(negedge clk);
        checkOutput("drain", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
